// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply: radix-2 shift-add. Divide: radix-2 restoring division.
// Both work on operand magnitudes; signs are applied when the result is written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    // acc: multiply = {partial high, multiplier/low product};
    //      divide   = {remainder, dividend/quotient shift register}
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic                 is_div;
    logic                 neg_q;     // product sign / quotient sign
    logic                 neg_r;     // remainder sign (dividend sign)
    logic                 bzero;

    // Request decode; a start under flush is dropped in IDLE.
    logic             req_md, req_mt, sgn_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign req_md = start && !flush && !op[2];
    assign req_mt = start && !flush && (op == OP_MTHI || op == OP_MTLO);
    assign sgn_op = ~op[0];
    assign sa     = sgn_op & a[WIDTH-1];
    assign sb     = sgn_op & b[WIDTH-1];
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;

    // One iteration of shift-add and restoring division.
    logic [WIDTH:0]       mul_sum, div_sh, div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh  = acc[2*WIDTH-1:WIDTH-1];
    assign div_ge  = div_sh >= {1'b0, opnd};
    assign div_rem = div_ge ? div_sh - {1'b0, opnd} : div_sh;
    assign div_nxt = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

    // Sign correction at writeback. Divide-by-zero forces the quotient to
    // all ones; the remainder already equals |a| and its sign restores a.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
    assign prod_s = neg_q ? -acc : acc;
    assign quo    = acc[WIDTH-1:0];
    assign rem    = acc[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (bzero ? '1 : (neg_q ? -quo : quo)) : prod_s[WIDTH-1:0];
    assign res_hi = is_div ? (neg_r ? -rem : rem) : prod_s[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: WIDTH iterations in RUN, one writeback cycle in FIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_md) state_nxt = RUN;
            RUN:     if (flush) state_nxt = IDLE;
                     else if (cnt == CW'(WIDTH-1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, HI/LO and the registered done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            bzero  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_md) begin
                        acc    <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                        opnd   <= op[1] ? mag_b : mag_a;
                        cnt    <= '0;
                        is_div <= op[1];
                        neg_q  <= sa ^ sb;
                        neg_r  <= sa;
                        bzero  <= (b == '0);
                    end else if (req_mt) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    if (!flush) begin
                        acc <= is_div ? div_nxt : mul_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO result registers, parametrised in operand width. It executes signed/unsigned multiply and divide over multiple cycles, plus single-cycle HI/LO writes. It sits beside the combinational ALU in the execute stage, and the pipeline stalls on `busy`. It adds a start/busy/done handshake, a flush, and defined divide-by-zero and overflow results.

## Interface
- `WIDTH`, 32: operand width; HI, LO, a, b are each WIDTH bits; WIDTH ≥ 4, even.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `a` in WIDTH: multiplicand/dividend, or MTHI/MTLO source.
- `b` in WIDTH: multiplier/divisor.
- `flush` in 1: abandon the in-flight operation.
- `busy` out 1: high in RUN or FIN.
- `done` out 1: one-cycle pulse; HI/LO are valid and updated.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- FSM states are IDLE, RUN, FIN. `busy = (state != IDLE)`.
- **IDLE, start=1, op MULT/MULTU/DIV/DIVU:**
  - Latch the operand magnitudes. For signed ops, take the two's-complement absolute value; for unsigned ops, take the operands as-is.
  - Record the result signs.
  - Clear the iteration counter and go to RUN.
- **IDLE, start=1, op MTHI/MTLO:**
  - Write `a` into hi (MTHI) or lo (MTLO) at that edge.
  - `done`=1 in the next cycle; stay in IDLE.
- **IDLE, start=1, op 110/111:** no state change and no done.
- **RUN:** one iteration per cycle for exactly WIDTH cycles; the counter runs 0..WIDTH-1, then the FSM goes to FIN.
  - Multiply is radix-2 shift-add over the 2·WIDTH-bit product of the magnitudes.
  - Divide is radix-2 restoring division on the magnitudes.
- **FIN:** apply sign correction, write hi/lo, go to IDLE. `done`=1 in the following cycle.
- **start while busy:** ignored; it is not queued.
- **Result mapping:**
  - Multiply: {hi,lo} = full 2·WIDTH-bit product. Signed product is negated if the operand signs differ.
  - Divide: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the dividend's sign.
- **Divide by zero (b==0), signed or unsigned:** lo = all ones, hi = a. Falls out of restoring division on magnitudes; the signed case is forced to these values at FIN.
- **Signed overflow (a = most negative, b = −1):** lo = most negative, hi = 0.
- **flush=1 in RUN or FIN:** go to IDLE at that edge. hi/lo are unchanged, no done is produced, and flush has priority over FIN's writeback.
- **flush in IDLE:** no effect. A simultaneous start in IDLE with flush=1 is also ignored.
- **Reset** (asserted at any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, done=0, busy=0; counter and operand registers cleared.
  - No writeback from the interrupted operation.

## Timing
- Start accepted at edge E0 (IDLE, start=1).
- Multiply/divide:
  - busy=1 from after E0 through the cycle after edge E(WIDTH).
  - hi/lo update at edge E(WIDTH+1), when FIN exits.
  - done=1 during the cycle following E(WIDTH+1).
  - Latency from start edge to results visible: WIDTH+1 cycles (33 for WIDTH=32).
- MTHI/MTLO: hi/lo visible after E0; done=1 during the cycle after E0.
- Back-to-back: a new start is accepted in the same cycle done is high (state is IDLE).
- hi/lo are registered outputs and are never combinationally dependent on the inputs.
- done is registered and is never high for two consecutive cycles from one operation.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE; one done pulse.
- MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0x00000000. Then MTLO a=0x12345678 → lo=0x12345678 after 1 edge, done the next cycle, hi unchanged.
- Busy and flush:
  - Start a MULT, then pulse start with a DIV at cycle 5 → the DIV is ignored and the MULT result is unchanged.
  - Separately, start a DIV and assert flush at cycle 10 → busy drops next cycle, no done, hi/lo keep their prior values.
- Reset and parameter:
  - Deassert reset_n asynchronously mid-RUN → busy, done, hi, lo all 0 immediately.
  - Re-run with WIDTH=8: MULTU 0xFF·0xFF → hi=0xFE, lo=0x01; done after 9 cycles.
